// File: rtl/conv_pool_writeback.sv
// conv_pool_writeback
// Takes finished convolution pixels in raster order, quantizes them to
// DATA_WIDTH (arithmetic shift by FRAC_SHIFT, then saturation), 2x2
// max-pools them on the fly and writes one pooled pixel per window to the
// output feature memory.
//
// Build option: define POOL_RELU_EN to clamp negative quantized values to
// zero before pooling. Without it, signed values pass unchanged.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   start      single-cycle frame start pulse (also restarts a running frame)
//   acc_valid  one-cycle strobe, acc_data holds one conv pixel
//   acc_data   signed accumulator result
//   out_wren   write strobe to the pooled output memory (one cycle per write)
//   out_addr   pooled write address
//   out_data   pooled pixel
//   busy       high while a frame is being processed
//   pool_done  sticky frame-complete flag, cleared by start or reset
module conv_pool_writeback #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int FRAC_SHIFT = 8,
  parameter int OUT_W      = 8,
  parameter int OUT_H      = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  acc_valid,
  input  logic [ACC_WIDTH-1:0]  acc_data,
  output logic                  out_wren,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  pool_done
);

  localparam int CW       = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int RW       = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int LB_DEPTH = OUT_W / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  // Saturation bounds, sign-extended to the accumulator width.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_reg, state_next;

  logic signed [DATA_WIDTH-1:0] q_reg, h_reg;
  logic                         q_valid_reg;
  logic [CW-1:0]                col_reg;
  logic [RW-1:0]                row_reg;

  // One row of horizontally pooled pairs; small enough for distributed
  // memory, read asynchronously so the window closes one cycle after q.
  logic signed [DATA_WIDTH-1:0] lb [LB_DEPTH];

  logic signed [ACC_WIDTH-1:0]  shifted;
  logic signed [DATA_WIDTH-1:0] sat_val, quant_val;
  logic signed [DATA_WIDTH-1:0] hm, lb_rd, pool_val;
  logic [LB_AW-1:0]             lb_idx;
  logic [ADDR_WIDTH-1:0]        write_addr;
  logic                         process, write_issue, last_write, col_last;

  // Quantize: shift, saturate, optional ReLU.
  always_comb begin
    shifted = $signed(acc_data) >>> FRAC_SHIFT;
    if (shifted > SAT_MAX)
      sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (shifted < SAT_MIN)
      sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      sat_val = shifted[DATA_WIDTH-1:0];
`ifdef POOL_RELU_EN
    quant_val = sat_val[DATA_WIDTH-1] ? '0 : sat_val;
`else
    quant_val = sat_val;
`endif
  end

  // Pooling datapath for the pixel currently held in q.
  always_comb begin
    lb_idx      = LB_AW'(col_reg >> 1);
    hm          = (q_reg > h_reg) ? q_reg : h_reg;
    lb_rd       = lb[lb_idx];
    pool_val    = (lb_rd > hm) ? lb_rd : hm;
    write_addr  = ADDR_WIDTH'(row_reg >> 1) * ADDR_WIDTH'(OUT_W / 2)
                + ADDR_WIDTH'(col_reg >> 1);
    col_last    = (col_reg == CW'(OUT_W - 1));
    // A start in the same cycle discards whatever is in flight.
    process     = q_valid_reg && (state_reg == RUN) && !start;
    write_issue = process && col_reg[0] && row_reg[0];
    last_write  = write_issue && col_last && (row_reg == RW'(OUT_H - 1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (start) state_next = RUN;
               else if (last_write) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg == RUN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_reg       <= '0;
      q_valid_reg <= 1'b0;
      h_reg       <= '0;
      col_reg     <= '0;
      row_reg     <= '0;
      out_wren    <= 1'b0;
      out_addr    <= '0;
      out_data    <= '0;
      pool_done   <= 1'b0;
    end else begin
      out_wren    <= 1'b0;
      q_valid_reg <= 1'b0;
      if (start) begin
        col_reg   <= '0;
        row_reg   <= '0;
        h_reg     <= '0;
        out_addr  <= '0;
        pool_done <= 1'b0;
      end else begin
        if (acc_valid && state_reg == RUN) begin
          q_reg       <= quant_val;
          q_valid_reg <= 1'b1;
        end
        if (process) begin
          if (!col_reg[0]) h_reg <= q_reg;
          if (col_last) begin
            col_reg <= '0;
            row_reg <= (row_reg == RW'(OUT_H - 1)) ? '0 : row_reg + 1'b1;
          end else begin
            col_reg <= col_reg + 1'b1;
          end
        end
        if (write_issue) begin
          out_wren <= 1'b1;
          out_addr <= write_addr;
          out_data <= pool_val;
        end
        if (last_write) pool_done <= 1'b1;
      end
    end
  end

  // Even rows park their horizontal maxima for the odd row below.
  always_ff @(posedge clock) begin
    if (process && col_reg[0] && !row_reg[0])
      lb[lb_idx] <= hm;
  end

endmodule
